// File: rtl/add_pipe.sv
// Pipelined adder/subtractor: WIDTH-bit operands are added CHUNK bits per stage with the carry
// registered between stages, using valid/ready handshakes and carry/overflow/zero/negative flags.
module add_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int STAGES = WIDTH / CHUNK;

  logic adv;
  logic ovfD, zeroD, negD;
  logic ovfQ, zeroQ, negQ;

  // One global stall: the whole pipe moves only when the output register can be refilled.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    localparam int REM  = WIDTH - k * CHUNK;
    localparam int DONE = (k + 1) * CHUNK;

    logic [REM-1:0]  aRem, bRem;
    logic            cIn, vIn;
    logic [CHUNK:0]  slice;
    logic [DONE-1:0] sD, sQ;
    logic            cQ, vQ;

    if (k == 0) begin : gIn
      assign aRem = a;
      assign bRem = sub ? ~b : b;
      assign cIn  = sub;
      assign vIn  = in_valid;
      assign sD   = slice[CHUNK-1:0];
    end else begin : gLink
      assign aRem = gStage[k-1].gFwd.aQ;
      assign bRem = gStage[k-1].gFwd.bQ;
      assign cIn  = gStage[k-1].cQ;
      assign vIn  = gStage[k-1].vQ;
      assign sD   = {slice[CHUNK-1:0], gStage[k-1].sQ};
    end

    assign slice = {1'b0, aRem[CHUNK-1:0]} + {1'b0, bRem[CHUNK-1:0]} + {{CHUNK{1'b0}}, cIn};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sQ <= '0;
        cQ <= 1'b0;
        vQ <= 1'b0;
      end else if (adv) begin
        sQ <= sD;
        cQ <= slice[CHUNK];
        vQ <= vIn;
      end
    end

    // Only the slices not yet added travel on to the next stage.
    if (k < STAGES - 1) begin : gFwd
      logic [REM-CHUNK-1:0] aQ, bQ;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          aQ <= '0;
          bQ <= '0;
        end else if (adv) begin
          aQ <= aRem[REM-1:CHUNK];
          bQ <= bRem[REM-1:CHUNK];
        end
      end
    end
  end

  // Carry into the MSB is recovered as a ^ b' ^ sum at the top bit of the last slice.
  assign ovfD  = gStage[STAGES-1].aRem[CHUNK-1] ^ gStage[STAGES-1].bRem[CHUNK-1]
               ^ gStage[STAGES-1].slice[CHUNK-1] ^ gStage[STAGES-1].slice[CHUNK];
  assign zeroD = ~|gStage[STAGES-1].sD;
  assign negD  = gStage[STAGES-1].sD[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovfQ  <= 1'b0;
      zeroQ <= 1'b0;
      negQ  <= 1'b0;
    end else if (adv) begin
      ovfQ  <= ovfD;
      zeroQ <= zeroD;
      negQ  <= negD;
    end
  end

  assign sum       = gStage[STAGES-1].sQ;
  assign cout      = gStage[STAGES-1].cQ;
  assign out_valid = gStage[STAGES-1].vQ;
  assign ovf       = ovfQ;
  assign zero      = zeroQ;
  assign neg       = negQ;

endmodule

// File: tb/tb_add_pipe.sv
// Directed bench for add_pipe: a 16-bit/4-bit-chunk pipe and an 8-bit single-stage pipe,
// checking results, flags, latency, stall behaviour, ordering and asynchronous reset.
module tb_add_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        inValid16 = 1'b0, outReady16 = 1'b1, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        inReady16, outValid16, cout16, ovf16, zero16, neg16;
  logic [15:0] sum16;

  logic        inValid8 = 1'b0, outReady8 = 1'b1, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        inReady8, outValid8, cout8, ovf8, zero8, neg8;
  logic [7:0]  sum8;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  add_pipe #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(inValid16), .in_ready(inReady16),
    .a(a16), .b(b16), .sub(sub16), .out_valid(outValid16), .out_ready(outReady16),
    .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16), .neg(neg16)
  );

  add_pipe #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(inValid8), .in_ready(inReady8),
    .a(a8), .b(b8), .sub(sub8), .out_valid(outValid8), .out_ready(outReady8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8), .neg(neg8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
  endtask

  // Outputs are sampled 1ns after the rising edge, where inputs are also changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one op into the 16-bit pipe; lat counts edges from the accepting edge until out_valid.
  task automatic applyStimulus(input logic [15:0] aIn, input logic [15:0] bIn, input logic subIn,
                               output int lat);
    a16 = aIn; b16 = bIn; sub16 = subIn; inValid16 = 1'b1; outReady16 = 1'b1;
    tick();
    inValid16 = 1'b0;
    lat = 1;
    while (!outValid16 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic applyStimulus8(input logic [7:0] aIn, input logic [7:0] bIn, input logic subIn,
                                output int lat);
    a8 = aIn; b8 = bIn; sub8 = subIn; inValid8 = 1'b1; outReady8 = 1'b1;
    tick();
    inValid8 = 1'b0;
    lat = 1;
    while (!outValid8 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [15:0] expQ[$];
    int received, stallCycles, readyInStall, cyc, sent, lateValid;

    #12;
    rst = 1'b0;
    #1;
    checkOutput("reset out_valid", {31'b0, outValid16}, 32'd0);
    checkOutput("reset sum", {16'b0, sum16}, 32'd0);
    checkOutput("reset flags", {28'b0, cout16, ovf16, zero16, neg16}, 32'd0);
    checkOutput("reset in_ready", {31'b0, inReady16}, 32'd1);

    // Plain add, latency of four stages
    tick();
    applyStimulus(16'h0001, 16'h1080, 1'b0, lat);
    checkOutput("t1 latency", lat, 32'd4);
    checkOutput("t1 sum", {16'b0, sum16}, 32'h1081);
    checkOutput("t1 flags c/o/z/n", {28'b0, cout16, ovf16, zero16, neg16}, 32'b0000);

    applyStimulus(16'h8001, 16'h8003, 1'b0, lat);
    checkOutput("t2 sum", {16'b0, sum16}, 32'h0004);
    checkOutput("t2 flags c/o/z/n", {28'b0, cout16, ovf16, zero16, neg16}, 32'b1100);

    applyStimulus(16'h0001, 16'hFFFB, 1'b0, lat);
    checkOutput("t3 add sum", {16'b0, sum16}, 32'hFFFC);
    checkOutput("t3 add flags c/o/z/n", {28'b0, cout16, ovf16, zero16, neg16}, 32'b0001);

    applyStimulus(16'h0001, 16'h0005, 1'b1, lat);
    checkOutput("t3 sub sum", {16'b0, sum16}, 32'hFFFC);
    checkOutput("t3 sub flags c/o/z/n", {28'b0, cout16, ovf16, zero16, neg16}, 32'b0001);
    tick();

    // Eight back-to-back ops with the consumer stalled for cycles 3-6
    received = 0; stallCycles = 0; readyInStall = 0; sent = 0; cyc = 0;
    while (received < 8 && cyc < 60) begin
      outReady16 = !(cyc >= 3 && cyc <= 6);
      inValid16  = (sent < 8);
      a16   = 16'h1111 * sent[15:0];
      b16   = 16'h0100 + sent[15:0];
      sub16 = sent[0];
      #1;
      if (outValid16 && !outReady16) begin
        stallCycles++;
        if (inReady16) readyInStall++;
      end
      if (outValid16 && outReady16) begin
        if (expQ.size() > 0) checkOutput($sformatf("t4 result %0d", received), {16'b0, sum16}, {16'b0, expQ.pop_front()});
        else checkOutput("t4 unexpected result", 32'd1, 32'd0);
        received++;
      end
      if (inValid16 && inReady16) begin
        expQ.push_back(sub16 ? a16 - b16 : a16 + b16);
        sent++;
      end
      tick();
      cyc++;
    end
    inValid16 = 1'b0; outReady16 = 1'b1;
    checkOutput("t4 results received", received, 32'd8);
    checkOutput("t4 stall cycles", stallCycles, 32'd3);
    checkOutput("t4 in_ready high in stall", readyInStall, 32'd0);

    // Reset with three ops in flight and a flagged result at the output
    a16 = 16'h8000; b16 = 16'h8000; sub16 = 1'b0; inValid16 = 1'b1;
    tick(); tick(); tick();
    inValid16 = 1'b0;
    tick();
    checkOutput("t5 pre-reset flags c/o/z/n", {27'b0, outValid16, cout16, ovf16, zero16, neg16}, 32'b11110);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5 reset out_valid", {31'b0, outValid16}, 32'd0);
    checkOutput("t5 reset flags c/o/z/n", {28'b0, cout16, ovf16, zero16, neg16}, 32'b0000);
    checkOutput("t5 reset sum", {16'b0, sum16}, 32'd0);
    #1 rst = 1'b0;
    lateValid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (outValid16) lateValid++;
    end
    checkOutput("t5 results after reset", lateValid, 32'd0);

    // Single-stage 8-bit pipe
    applyStimulus8(8'h7F, 8'h01, 1'b0, lat);
    checkOutput("t6 latency", lat, 32'd1);
    checkOutput("t6 add sum", {24'b0, sum8}, 32'h80);
    checkOutput("t6 add flags c/o/z/n", {28'b0, cout8, ovf8, zero8, neg8}, 32'b0101);
    applyStimulus8(8'h05, 8'h05, 1'b1, lat);
    checkOutput("t6 sub sum", {24'b0, sum8}, 32'h00);
    checkOutput("t6 sub flags c/o/z/n", {28'b0, cout8, ovf8, zero8, neg8}, 32'b1010);
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
